timer_counter: RTL and testbench

//  Timer counting stage for the 8-bit timer. Produces counter_value for the downstream overflow/underflow compare stage.

---
 rtl/timer_counter.sv | 86 ++++++++
 tb/tb_timer_counter.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/timer_counter.sv
// Prescaled up/down timer counter with parallel load and registered wrap pulses.
// Feeds counter_value to the downstream overflow/underflow compare stage.
module timer_counter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned PSC_W = 4
) (
  input  logic             PCLK,
  input  logic             PRESET,
  input  logic [7:0]       reg_TCR,
  input  logic [WIDTH-1:0] reg_TDR,
  output logic [WIDTH-1:0] counter_value,
  output logic             cnt_tick,
  output logic             ovf_evt,
  output logic             udf_evt
);

  logic             load_c;
  logic             down_c;
  logic             enable_c;
  logic [PSC_W-1:0] mask_c;
  logic             tick_c;
  logic             unused_tcr_c;

  logic [PSC_W-1:0] psc_q,      psc_d;
  logic [WIDTH-1:0] cnt_q,      cnt_d;
  logic             cnt_tick_q, cnt_tick_d;
  logic             ovf_q,      ovf_d;
  logic             udf_q,      udf_d;

  assign load_c       = reg_TCR[7];
  assign down_c       = reg_TCR[5];
  assign enable_c     = reg_TCR[4];
  assign unused_tcr_c = ^{reg_TCR[6], reg_TCR[3:2]};

  // Clock select 0..3 gives mask 1,3,7,15 (division 2,4,8,16).
  assign mask_c = PSC_W'((32'd2 << reg_TCR[1:0]) - 32'd1);
  assign tick_c = enable_c & ~load_c & ((psc_q & mask_c) == mask_c);

  always_comb begin
    psc_d      = psc_q + PSC_W'(1);
    cnt_d      = cnt_q;
    cnt_tick_d = 1'b0;
    ovf_d      = 1'b0;
    udf_d      = 1'b0;

    if (load_c || !enable_c) begin
      psc_d = '0;
    end

    // Load suppresses counting and never produces pulses.
    if (load_c) begin
      cnt_d = reg_TDR;
    end else if (tick_c) begin
      cnt_tick_d = 1'b1;
      if (down_c) begin
        cnt_d = cnt_q - WIDTH'(1);
        udf_d = (cnt_q == '0);
      end else begin
        cnt_d = cnt_q + WIDTH'(1);
        ovf_d = (cnt_q == {WIDTH{1'b1}});
      end
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      psc_q      <= '0;
      cnt_q      <= '0;
      cnt_tick_q <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      psc_q      <= psc_d;
      cnt_q      <= cnt_d;
      cnt_tick_q <= cnt_tick_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
    end
  end

  assign counter_value = cnt_q;
  assign cnt_tick      = cnt_tick_q;
  assign ovf_evt       = ovf_q;
  assign udf_evt       = udf_q;

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter: load, prescaled up/down counting, wraps,
// enable gating and reset override, against hand-computed values.
module tb_timer_counter;

  logic       PCLK;
  logic       PRESET;
  logic [7:0] reg_TCR;
  logic [7:0] reg_TDR;
  logic [7:0] counter_value;
  logic       cnt_tick;
  logic       ovf_evt;
  logic       udf_evt;

  int checks;
  int failures;

  timer_counter #(.WIDTH(8), .PSC_W(4)) dut (
    .PCLK          (PCLK),
    .PRESET        (PRESET),
    .reg_TCR       (reg_TCR),
    .reg_TDR       (reg_TDR),
    .counter_value (counter_value),
    .cnt_tick      (cnt_tick),
    .ovf_evt       (ovf_evt),
    .udf_evt       (udf_evt)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One rising edge; outputs are then stable for sampling and inputs may change.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge PCLK);
      #1;
    end
  endtask

  task automatic expect_state(input string tag, input logic [7:0] cnt,
                              input logic tk, input logic ov, input logic ud);
    check({tag, ".cnt"}, 32'(counter_value), 32'(cnt));
    check({tag, ".tick"}, 32'(cnt_tick), 32'(tk));
    check({tag, ".ovf"}, 32'(ovf_evt), 32'(ov));
    check({tag, ".udf"}, 32'(udf_evt), 32'(ud));
  endtask

  task automatic load(input logic [7:0] v);
    reg_TDR = v;
    reg_TCR = 8'h80;
    step(1);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    PRESET   = 1'b1;
    reg_TCR  = 8'h00;
    reg_TDR  = 8'h00;
    step(3);
    expect_state("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    PRESET = 1'b0;

    // 1: idle after reset holds zero
    for (int i = 0; i < 20; i++) begin
      step(1);
      check("idle.cnt", 32'(counter_value), 32'h00);
    end
    expect_state("idle.end", 8'h00, 1'b0, 1'b0, 1'b0);

    // 2: load 0x5A then count up /2
    load(8'h5A);
    expect_state("t2.load", 8'h5A, 1'b0, 1'b0, 1'b0);
    reg_TCR = 8'h10;
    step(1); expect_state("t2.e1", 8'h5A, 1'b0, 1'b0, 1'b0);
    step(1); expect_state("t2.e2", 8'h5B, 1'b1, 1'b0, 1'b0);
    step(1); expect_state("t2.e3", 8'h5B, 1'b0, 1'b0, 1'b0);
    step(1); expect_state("t2.e4", 8'h5C, 1'b1, 1'b0, 1'b0);

    // 3: up /16 through the FF->00 wrap
    load(8'hFE);
    expect_state("t3.load", 8'hFE, 1'b0, 1'b0, 1'b0);
    reg_TCR = 8'h13;
    step(15); expect_state("t3.e15", 8'hFE, 1'b0, 1'b0, 1'b0);
    step(1);  expect_state("t3.e16", 8'hFF, 1'b1, 1'b0, 1'b0);
    step(15); expect_state("t3.e31", 8'hFF, 1'b0, 1'b0, 1'b0);
    step(1);  expect_state("t3.e32", 8'h00, 1'b1, 1'b1, 1'b0);
    step(1);  expect_state("t3.e33", 8'h00, 1'b0, 1'b0, 1'b0);

    // Loading a wrap value never pulses
    load(8'hFF);
    expect_state("ldff", 8'hFF, 1'b0, 1'b0, 1'b0);
    load(8'h00);
    expect_state("ld00", 8'h00, 1'b0, 1'b0, 1'b0);

    // 4: down /2 through the 00->FF wrap
    load(8'h01);
    reg_TCR = 8'h30;
    step(1); expect_state("t4.e1", 8'h01, 1'b0, 1'b0, 1'b0);
    step(1); expect_state("t4.e2", 8'h00, 1'b1, 1'b0, 1'b0);
    step(1); expect_state("t4.e3", 8'h00, 1'b0, 1'b0, 1'b0);
    step(1); expect_state("t4.e4", 8'hFF, 1'b1, 1'b0, 1'b1);
    step(1); expect_state("t4.e5", 8'hFF, 1'b0, 1'b0, 1'b0);
    step(1); expect_state("t4.e6", 8'hFE, 1'b1, 1'b0, 1'b0);

    // 5: up /4 with enable dropped mid-period
    load(8'h10);
    reg_TCR = 8'h11;
    step(3); expect_state("t5.e3", 8'h10, 1'b0, 1'b0, 1'b0);
    step(1); expect_state("t5.e4", 8'h11, 1'b1, 1'b0, 1'b0);
    step(2);
    reg_TCR = 8'h01;
    for (int i = 0; i < 5; i++) begin
      step(1);
      expect_state("t5.off", 8'h11, 1'b0, 1'b0, 1'b0);
    end
    reg_TCR = 8'h11;
    step(3); expect_state("t5.re3", 8'h11, 1'b0, 1'b0, 1'b0);
    step(1); expect_state("t5.re4", 8'h12, 1'b1, 1'b0, 1'b0);

    // Load and enable together: load wins, counting restarts from psc=0
    reg_TDR = 8'h40;
    reg_TCR = 8'h90;
    step(2); expect_state("ldén", 8'h40, 1'b0, 1'b0, 1'b0);
    reg_TCR = 8'h10;
    step(1); expect_state("ldén.e1", 8'h40, 1'b0, 1'b0, 1'b0);
    step(1); expect_state("ldén.e2", 8'h41, 1'b1, 1'b0, 1'b0);

    // 6: reset mid-count overrides a simultaneous load
    step(1);
    reg_TDR = 8'hA5;
    reg_TCR = 8'h90;
    PRESET  = 1'b1;
    step(1); expect_state("t6.rst", 8'h00, 1'b0, 1'b0, 1'b0);
    PRESET = 1'b0;
    step(1); expect_state("t6.load", 8'hA5, 1'b0, 1'b0, 1'b0);
    reg_TCR = 8'h10;
    step(1); expect_state("t6.e1", 8'hA5, 1'b0, 1'b0, 1'b0);
    step(1); expect_state("t6.e2", 8'hA6, 1'b1, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
